rr_grant_arbiter_4: RTL and testbench



---
 rtl/rr_grant_arbiter_4_pkg.sv | 31 +++
 rtl/rr_grant_arbiter_4_pick.sv | 26 ++
 rtl/rr_grant_arbiter_4.sv | 99 +++++++++
 tb/tb_rr_grant_arbiter_4.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_4_pkg.sv
// Shared definitions for the 4-source round-robin grant arbiter:
// width constants, FSM state encoding and the rotating first-set-bit helper.
package rr_grant_arbiter_4_pkg;

  localparam int unsigned ARB_N = 4;
  localparam int unsigned ARB_W = 2;

  typedef enum logic {
    StIdle,
    StGrant
  } arb_state_e;

  // One-hot of the first set bit of vec, searching ptr, ptr+1, ... modulo ARB_N.
  function automatic logic [ARB_N-1:0] first_from_ptr(input logic [ARB_N-1:0] vec,
                                                      input logic [ARB_W-1:0] ptr);
    logic [ARB_N-1:0] onehot;
    logic             found;
    logic [ARB_W-1:0] idx;
    onehot = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < ARB_N; i++) begin
      idx = ptr + ARB_W'(i);
      if (!found && vec[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_4_pick.sv
// Combinational round-robin pick: rotate pending so ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot back.
module rr_pick_4
  import rr_grant_arbiter_4_pkg::*;
(
  input  logic [ARB_N-1:0] pending,
  input  logic [ARB_W-1:0] ptr,
  output logic [ARB_N-1:0] pick,
  output logic             pick_valid
);

  logic [2*ARB_N-1:0] rot_dbl;
  logic [2*ARB_N-1:0] unrot_dbl;
  logic [ARB_N-1:0]   rotated;
  logic [ARB_N-1:0]   prio;

  always_comb begin
    rot_dbl    = {pending, pending} >> ptr;
    rotated    = rot_dbl[ARB_N-1:0];
    prio       = first_from_ptr(rotated, '0);
    unrot_dbl  = {prio, prio} << ptr;
    pick       = unrot_dbl[2*ARB_N-1:ARB_N];
    pick_valid = |pending;
  end

endmodule

// File: rtl/rr_grant_arbiter_4.sv
// Round-robin arbiter over four sticky request bits, presenting a registered
// one-hot grant held under a valid/ready handshake.
module rr_grant_arbiter_4
  import rr_grant_arbiter_4_pkg::*;
#(
  parameter int unsigned N         = ARB_N,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [N-1:0] pending,
  output logic         dropped
);

  localparam logic [ARB_W-1:0] PtrInit = ARB_W'(PRIO_INIT);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [ARB_W-1:0] ptr_q, ptr_d;
  logic             dropped_q, dropped_d;

  logic [N-1:0]     pick;
  logic             pick_valid;
  logic             accept;
  logic [N-1:0]     clear;
  logic [ARB_W-1:0] grant_idx;

  rr_pick_4 u_pick (
    .pending   (pending_q),
    .ptr       (ptr_q),
    .pick      (pick),
    .pick_valid(pick_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) grant_idx = ARB_W'(i);
    end
  end

  always_comb begin
    accept    = (state_q == StGrant) && grant_ready;
    clear     = accept ? grant_q : '0;
    // A fresh request on the bit being cleared re-arms it rather than dropping.
    pending_d = (pending_q & ~clear) | req_in;
    dropped_d = |(req_in & pending_q & ~clear);

    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          grant_d = '0;
          ptr_d   = grant_idx + 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      ptr_q     <= PtrInit;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      dropped_q <= dropped_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == StGrant);
  assign pending     = pending_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// Bench for rr_grant_arbiter_4: directed literal scenarios plus random traffic,
// all cycles checked against a behavioural round-robin model.
module tb_rr_grant_arbiter_4;

  localparam int PRIO_INIT = 0;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] grant;
  logic       grant_valid;
  logic       grant_ready;
  logic [3:0] pending;
  logic       dropped;

  int n_total = 0;
  int n_pass  = 0;

  rr_grant_arbiter_4 #(
    .N        (4),
    .PRIO_INIT(PRIO_INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .pending    (pending),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: sticky pending set, pointer, and index of held grant.
  logic [3:0] mpend;
  logic       mvalid;
  int         midx;
  int         mptr;
  logic       mdrop;
  logic       started = 1'b0;
  logic [3:0] mclr;

  function automatic int first_idx(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  always_comb mclr = (mvalid && grant_ready) ? 4'(1 << midx) : 4'b0000;

  always @(posedge clk) begin
    if (rst) begin
      mpend   <= 4'b0000;
      mvalid  <= 1'b0;
      midx    <= 0;
      mptr    <= PRIO_INIT;
      mdrop   <= 1'b0;
      started <= 1'b1;
    end else begin
      mpend <= (mpend & ~mclr) | req_in;
      mdrop <= |(req_in & mpend & ~mclr);
      if (!mvalid) begin
        if (mpend != 4'b0000) begin
          mvalid <= 1'b1;
          midx   <= first_idx(mpend, mptr);
        end
      end else if (grant_ready) begin
        mvalid <= 1'b0;
        mptr   <= (midx + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_grant", grant, mvalid ? 4'(1 << midx) : 4'b0000);
      check("model_valid", {3'b0, grant_valid}, {3'b0, mvalid});
      check("model_pending", pending, mpend);
      check("model_dropped", {3'b0, dropped}, {3'b0, mdrop});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_seq [4];

  initial begin
    rst = 1'b1; req_in = 4'b0000; grant_ready = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", {3'b0, grant_valid}, 4'b0000);
    check("rst_pending", pending, 4'b0000);
    check("rst_dropped", {3'b0, dropped}, 4'b0000);

    // Single request, two-edge latency, then accept.
    grant_ready = 1'b1; req_in = 4'b0100;
    step();
    req_in = 4'b0000;
    check("t1_pending", pending, 4'b0100);
    step();
    check("t1_grant", grant, 4'b0100);
    check("t1_valid", {3'b0, grant_valid}, 4'b0001);
    step();
    check("t1_valid_after", {3'b0, grant_valid}, 4'b0000);
    check("t1_pending_after", pending, 4'b0000);

    // ptr=3 now: 1001 wraps 1000 then 0001, leaving ptr=1.
    req_in = 4'b1001;
    step();
    req_in = 4'b0000;
    step();
    check("wrap_first", grant, 4'b1000);
    step(2);
    check("wrap_second", grant, 4'b0001);
    step();
    // ptr=1 so 1001 must pick bit 3 first.
    req_in = 4'b1001;
    step();
    req_in = 4'b0000;
    step();
    check("wrap_ptr1", grant, 4'b1000);
    step(2);
    check("wrap_ptr1_b", grant, 4'b0001);
    step();

    // Fresh reset, all four requests serviced in order with gaps.
    rst = 1'b1;
    step();
    rst = 1'b0; req_in = 4'b1111;
    step();
    req_in = 4'b0000;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_grant", grant, exp_seq[k]);
      step();
      check("rr_gap", {3'b0, grant_valid}, 4'b0000);
    end
    check("rr_pending_end", pending, 4'b0000);

    // Backpressure holds grant stable.
    grant_ready = 1'b0; req_in = 4'b0011;
    step();
    req_in = 4'b0000;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_grant", grant, 4'b0001);
      check("bp_valid", {3'b0, grant_valid}, 4'b0001);
      step();
    end
    grant_ready = 1'b1;
    step();
    check("bp_gap", {3'b0, grant_valid}, 4'b0000);
    step();
    check("bp_next", grant, 4'b0010);
    step();

    // Same-bit overlap on accept: bit stays pending, no drop.
    grant_ready = 1'b0; req_in = 4'b0001;
    step();
    req_in = 4'b0000;
    step();
    check("ov_grant", grant, 4'b0001);
    grant_ready = 1'b1; req_in = 4'b0001;
    step();
    req_in = 4'b0000; grant_ready = 1'b0;
    check("ov_pending", pending, 4'b0001);
    check("ov_dropped", {3'b0, dropped}, 4'b0000);
    step();
    // Re-request an already pending bit: one-cycle drop pulse.
    req_in = 4'b0010;
    step();
    step();
    req_in = 4'b0000;
    check("drop_hi", {3'b0, dropped}, 4'b0001);
    step();
    check("drop_lo", {3'b0, dropped}, 4'b0000);

    // Reset in the middle of a held grant.
    rst = 1'b1;
    step();
    rst = 1'b0; req_in = 4'b0110;
    step();
    req_in = 4'b0000;
    step();
    check("mid_grant", grant, 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_valid", {3'b0, grant_valid}, 4'b0000);
    check("mid_rst_pending", pending, 4'b0000);
    step(3);
    check("mid_rst_quiet", {3'b0, grant_valid}, 4'b0000);
    req_in = 4'b1001;
    step();
    req_in = 4'b0000;
    step();
    check("mid_rst_ptr", grant, 4'b0001);

    // Random traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req_in      = 4'($urandom) & 4'($urandom) & 4'($urandom);
      grant_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; req_in = 4'b0000;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
